// File: rtl/ifu_rd_slave.sv
// AXI-Lite read responder for instruction fetch: one outstanding AR, window decode,
// optional wait latency, then a single-cycle read of a synchronous instruction SRAM.
module ifu_rd_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 65536,
  parameter int          LATENCY     = 0,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv_ar_valid_i,
  input  logic [31:0]   slv_ar_addr_i,
  output logic          slv_ar_ready_o,
  output logic          slv_r_valid_o,
  output logic [31:0]   slv_r_data_o,
  output logic [1:0]    slv_r_resp_o,
  input  logic          slv_r_ready_i,
  output logic          mem_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [3:0] CNT_INIT    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  // 33-bit window compare keeps the upper bound from wrapping at the top of the map.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr);
    logic [32:0] a_s;
    logic [32:0] lo_s;
    logic [32:0] hi_s;
    a_s  = {1'b0, addr};
    lo_s = {1'b0, BASE_ADDR};
    hi_s = lo_s + (33'(DEPTH_WORDS) << 2);
    if ((a_s < lo_s) || (a_s >= hi_s)) begin
      return RESP_DECERR;
    end else if (addr[1:0] != 2'b00) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off_s;
    off_s = addr - BASE_ADDR;
    return AW'(off_s >> 2);
  endfunction

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [1:0]    resp_r;
  logic          ar_ready_r;
  logic          r_valid_r;
  logic [31:0]   r_data_r;
  logic [1:0]    r_resp_r;
  logic          mem_en_r;
  logic [AW-1:0] mem_addr_r;

  logic [1:0]    ar_resp_s;
  logic [AW-1:0] ar_widx_s;

  assign ar_resp_s = decode_resp(slv_ar_addr_i);
  assign ar_widx_s = word_index(slv_ar_addr_i);

  // Transaction sequencer; every output is driven from a register here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      resp_r     <= RESP_OKAY;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_data_r   <= 32'h0;
      r_resp_r   <= RESP_OKAY;
      mem_en_r   <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_en_r <= 1'b0;
          if (ar_ready_r && slv_ar_valid_i) begin
            ar_ready_r <= 1'b0;
            resp_r     <= ar_resp_s;
            if (ar_resp_s == RESP_OKAY) begin
              mem_addr_r <= ar_widx_s;
            end else begin
              mem_addr_r <= mem_addr_r;
            end
            // The enable is raised on entry to READ so SRAM data lands in LATCH.
            if (LATENCY > 0) begin
              cnt_r   <= CNT_INIT;
              state_r <= DELAY;
            end else begin
              mem_en_r <= (ar_resp_s == RESP_OKAY);
              state_r  <= READ;
            end
          end else begin
            ar_ready_r <= 1'b1;
          end
        end
        DELAY: begin
          if (cnt_r == 4'd0) begin
            mem_en_r <= (resp_r == RESP_OKAY);
            state_r  <= READ;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        READ: begin
          mem_en_r <= 1'b0;
          state_r  <= LATCH;
        end
        LATCH: begin
          r_data_r  <= (resp_r == RESP_OKAY) ? mem_rdata_i : 32'h0;
          r_resp_r  <= resp_r;
          r_valid_r <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (slv_r_ready_i) begin
            r_valid_r  <= 1'b0;
            ar_ready_r <= 1'b1;
            state_r    <= IDLE;
          end else begin
            r_valid_r <= 1'b1;
          end
        end
        default: begin
          mem_en_r   <= 1'b0;
          r_valid_r  <= 1'b0;
          ar_ready_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign slv_ar_ready_o = ar_ready_r;
  assign slv_r_valid_o  = r_valid_r;
  assign slv_r_data_o   = r_data_r;
  assign slv_r_resp_o   = r_resp_r;
  assign mem_en_o       = mem_en_r;
  assign mem_addr_o     = mem_addr_r;

endmodule

// File: tb/tb_ifu_rd_slave.sv
// Bench for ifu_rd_slave: three instances (LATENCY 0, 3, 4) against an address-rule
// reference model and a behavioural synchronous SRAM.
module tb_ifu_rd_slave;

  localparam int NI = 3;
  localparam longint BASE  = 64'h8000_0000;
  localparam longint DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ar_valid [NI];
  logic [31:0] ar_addr  [NI];
  logic        ar_ready [NI];
  logic        r_valid  [NI];
  logic [31:0] r_data   [NI];
  logic [1:0]  r_resp   [NI];
  logic        r_ready  [NI];
  logic        mem_en   [NI];
  logic [15:0] mem_addr [NI];

  int checks    = 0;
  int failures  = 0;
  int last_wait = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    if (a == 16'h0) return 32'h0000_0413;
    else            return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic int lat_of(input int g);
    case (g)
      0:       return 0;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
    logic [31:0] rdata_q;
    always @(posedge clk) if (mem_en[g] === 1'b1) rdata_q <= sram_word(mem_addr[g]);
    ifu_rd_slave #(.LATENCY(LAT)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .slv_ar_valid_i (ar_valid[g]),
      .slv_ar_addr_i  (ar_addr[g]),
      .slv_ar_ready_o (ar_ready[g]),
      .slv_r_valid_o  (r_valid[g]),
      .slv_r_data_o   (r_data[g]),
      .slv_r_resp_o   (r_resp[g]),
      .slv_r_ready_i  (r_ready[g]),
      .mem_en_o       (mem_en[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_rdata_i    (rdata_q)
    );
  end

  // One full read on instance g; hold = cycles of R backpressure after valid rises.
  task automatic do_read(input int g, input logic [31:0] addr, input int hold, input string tag);
    longint      a;
    logic [1:0]  eresp;
    logic [15:0] eidx;
    logic [31:0] edata;
    logic [15:0] seen_idx;
    int          k;
    int          pulses;
    int          waitc;
    a = {32'h0, addr};
    if (a < BASE || a >= BASE + 4 * DEPTH) eresp = 2'b11;
    else if (a % 4 != 0)                   eresp = 2'b10;
    else                                   eresp = 2'b00;
    eidx  = 16'((a - BASE) / 4);
    edata = (eresp == 2'b00) ? sram_word(eidx) : 32'h0;

    waitc = 0;
    while (ar_ready[g] !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    last_wait = waitc;
    checks++;
    if (ar_ready[g] !== 1'b1) begin
      failures++; $display("FAIL %s ar_ready_wait: got %b want 1", tag, ar_ready[g]);
    end
    ar_valid[g] = 1'b1; ar_addr[g] = addr; r_ready[g] = (hold == 0);
    @(posedge clk); #1;
    ar_valid[g] = 1'b0; ar_addr[g] = $urandom;
    checks++;
    if (ar_ready[g] !== 1'b0) begin
      failures++; $display("FAIL %s ar_ready_drop: got %b want 0", tag, ar_ready[g]);
    end

    k = 0; pulses = 0; seen_idx = 16'h0;
    while (r_valid[g] !== 1'b1 && k < 40) begin
      if (mem_en[g] === 1'b1) begin pulses++; seen_idx = mem_addr[g]; end
      // Drive a valid AR mid-flight; it must be ignored outside IDLE.
      ar_valid[g] = 1'b1;
      @(posedge clk); #1; k++;
    end
    ar_valid[g] = 1'b0;
    checks++;
    if (k != 2 + lat_of(g)) begin
      failures++; $display("FAIL %s latency: got %0d want %0d", tag, k, 2 + lat_of(g));
    end
    checks++;
    if (pulses != ((eresp == 2'b00) ? 1 : 0)) begin
      failures++; $display("FAIL %s mem_en_pulses: got %0d want %0d", tag, pulses, (eresp == 2'b00) ? 1 : 0);
    end
    if (eresp == 2'b00) begin
      checks++;
      if (seen_idx !== eidx) begin
        failures++; $display("FAIL %s mem_addr: got %h want %h", tag, seen_idx, eidx);
      end
    end
    checks++;
    if (r_data[g] !== edata || r_resp[g] !== eresp) begin
      failures++; $display("FAIL %s rdata_resp: got %h/%b want %h/%b", tag, r_data[g], r_resp[g], edata, eresp);
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r_valid[g] !== 1'b1 || r_data[g] !== edata || r_resp[g] !== eresp ||
          ar_ready[g] !== 1'b0 || mem_en[g] !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: got v=%b d=%h r=%b ar=%b en=%b want v=1 d=%h r=%b ar=0 en=0",
                 tag, i, r_valid[g], r_data[g], r_resp[g], ar_ready[g], mem_en[g], edata, eresp);
      end
    end
    r_ready[g] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r_valid[g] !== 1'b0 || ar_ready[g] !== 1'b1) begin
      failures++; $display("FAIL %s r_handshake: got v=%b ar=%b want v=0 ar=1", tag, r_valid[g], ar_ready[g]);
    end
    r_ready[g] = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < NI; g++) begin
      ar_valid[g] = 1'b0; ar_addr[g] = 32'h0; r_ready[g] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (ar_ready[g] !== 1'b0 || r_valid[g] !== 1'b0 || r_data[g] !== 32'h0 ||
          r_resp[g] !== 2'b00 || mem_en[g] !== 1'b0 || mem_addr[g] !== 16'h0) begin
        failures++;
        $display("FAIL reset_values[%0d]: got ar=%b v=%b d=%h r=%b en=%b a=%h want all 0",
                 g, ar_ready[g], r_valid[g], r_data[g], r_resp[g], mem_en[g], mem_addr[g]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (ar_ready[g] !== 1'b1) begin
        failures++; $display("FAIL reset_release_ready[%0d]: got %b want 1", g, ar_ready[g]);
      end
    end
  endtask

  task automatic test_first_fetch();
    do_read(0, 32'h8000_0000, 0, "first_fetch");
  endtask

  task automatic test_latency();
    do_read(1, 32'h8000_0010, 0, "latency3");
    do_read(2, 32'h8000_0020, 0, "latency4");
  endtask

  task automatic test_backpressure();
    do_read(0, 32'h8000_0104, 6, "backpressure");
    do_read(1, 32'h8000_0008, 6, "backpressure_lat3");
  endtask

  task automatic test_errors();
    do_read(0, 32'h7FFF_FFFC, 0, "decerr_below");
    do_read(0, 32'h8000_0002, 0, "slverr_misalign");
    do_read(1, 32'h8000_0001, 2, "slverr_lat3");
    do_read(0, 32'hFFFF_FFFF, 0, "decerr_top");
    do_read(0, 32'h7FFF_FFFE, 0, "decerr_priority");
  endtask

  task automatic test_window_edges();
    do_read(0, 32'h8004_0000, 0, "first_out_of_window");
    do_read(0, 32'h8003_FFFC, 0, "last_word");
    do_read(2, 32'h8003_FFFC, 1, "last_word_lat4");
  endtask

  task automatic test_back_to_back();
    do_read(0, 32'h8000_0040, 0, "b2b_a");
    do_read(0, 32'h8000_0044, 0, "b2b_b");
    checks++;
    if (last_wait != 0) begin
      failures++; $display("FAIL back_to_back_accept: got wait %0d want 0", last_wait);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int waitc;
    waitc = 0;
    while (ar_ready[2] !== 1'b1 && waitc < 20) begin @(posedge clk); #1; waitc++; end
    ar_valid[2] = 1'b1; ar_addr[2] = 32'h8000_0030;
    @(posedge clk); #1;
    ar_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ar_ready[2] !== 1'b0 || r_valid[2] !== 1'b0 || r_data[2] !== 32'h0 ||
        r_resp[2] !== 2'b00 || mem_en[2] !== 1'b0 || mem_addr[2] !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_values: got ar=%b v=%b d=%h r=%b en=%b a=%h want all 0",
               ar_ready[2], r_valid[2], r_data[2], r_resp[2], mem_en[2], mem_addr[2]);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst = 1'b1;
      if (mem_en[2] !== 1'b0 || r_valid[2] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL reset_mid_no_pulse: got %0d activity cycles want 0", pulses);
    end
    do_read(2, 32'h8000_0030, 0, "after_reset_mid");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int g;
    for (int n = 0; n < 40; n++) begin
      g = $urandom_range(0, NI - 1);
      case ($urandom_range(0, 4))
        0:       addr = 32'h8000_0000 + ($urandom % 65536) * 4;
        1:       addr = 32'h8000_0000 + ($urandom % 65536) * 4 + $urandom_range(1, 3);
        2:       addr = 32'h8000_0000 - 4 * $urandom_range(1, 1000) + $urandom_range(0, 3);
        3:       addr = 32'h8004_0000 + $urandom_range(0, 4000);
        default: addr = $urandom;
      endcase
      do_read(g, addr, $urandom_range(0, 3), $sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_latency();
    test_backpressure();
    test_errors();
    test_window_edges();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_rd_slave.md
Name: ifu_rd_slave

Overview:
- AXI-Lite read-channel responder (slave) serving instruction fetches from the core's fetch master.
- Accepts one AR request at a time and decodes the address against a configurable window.
- For in-range, aligned addresses it reads a word from an external synchronous instruction SRAM; otherwise it returns an error response.
- Inserts a programmable wait latency so the fetch master's multi-cycle handshake paths are exercised.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address of the memory window.
- DEPTH_WORDS, 65536, window size in 32-bit words; must be a power of two.
- LATENCY, 0, extra wait cycles between AR handshake and the SRAM read; legal range 0..15.
- AW, $clog2(DEPTH_WORDS), SRAM word-address width (derived).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- slv_ar_valid_i  in  1  read address valid from the master.
- slv_ar_addr_i  in  32  byte address.
- slv_ar_ready_o  out  1  address accepted.
- slv_r_valid_o  out  1  read data valid.
- slv_r_data_o  out  32  read data.
- slv_r_resp_o  out  2  response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
- slv_r_ready_i  in  1  master accepts data.
- mem_en_o  out  1  SRAM read enable; data returned the following cycle.
- mem_addr_o  out  AW  SRAM word address.
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_en_o.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - slv_ar_ready_o=0, slv_r_valid_o=0, slv_r_data_o=0, slv_r_resp_o=2'b00.
  - mem_en_o=0, mem_addr_o=0, wait counter=0.
- Registered outputs:
  - slv_ar_ready_o is registered. It rises one cycle after reset deassertion and after every completed R handshake.
  - It falls on the edge that completes the AR handshake.
- States: IDLE, DELAY, READ, LATCH, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - On AR handshake (slv_ar_valid_i & slv_ar_ready_o), latch the address and compute resp.
  - Go to DELAY with counter=LATENCY-1 if LATENCY>0, else go to READ.
- resp decode:
  - addr[1:0]!=0 gives SLVERR (2'b10).
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS gives DECERR (2'b11).
  - DECERR has priority over SLVERR.
  - Otherwise OKAY.
  - Use 33-bit compare arithmetic so BASE_ADDR+4*DEPTH_WORDS never wraps.
- DELAY: decrement the counter each cycle; go to READ when counter==0. This gives exactly LATENCY cycles.
- READ:
  - If resp==OKAY: mem_en_o=1 for this single cycle, with mem_addr_o=(addr-BASE_ADDR)>>2, truncated to AW.
  - If resp is an error: mem_en_o stays 0.
  - Always go to LATCH.
- LATCH:
  - Capture slv_r_data_o <= (resp==OKAY) ? mem_rdata_i : 32'h0, and slv_r_resp_o <= resp.
  - Set slv_r_valid_o=1 and go to RESP.
- RESP:
  - Hold slv_r_valid_o, slv_r_data_o and slv_r_resp_o stable until slv_r_ready_i=1.
  - On R handshake: slv_r_valid_o<=0, slv_ar_ready_o<=1, go to IDLE.
- Latency:
  - With AR handshake at edge E, slv_r_valid_o is first high after edge E+2+LATENCY.
  - If slv_r_ready_i is held high, the next AR can be accepted at edge E+4+LATENCY.
  - Error responses follow identical timing.
- Other inputs:
  - slv_ar_valid_i is ignored outside IDLE.
  - slv_r_ready_i is ignored when slv_r_valid_o=0.
  - slv_r_ready_i already high before valid completes the handshake on valid's first cycle.
- Reset mid-transaction: return immediately to reset values and drop any in-flight response. No mem_en_o pulse occurs after reset assertion.
- mem_en_o is never asserted for an error transaction and never for more than one cycle per transaction.

Test Plan:
- Reset release, LATENCY=0, SRAM word 0 = 32'h0000_0413, AR addr 32'h8000_0000 at cycle 1, r_ready=1:
  - slv_ar_ready_o=1 in cycle 1.
  - mem_en_o=1 with mem_addr_o=0 one cycle after the handshake.
  - slv_r_valid_o=1 with data 32'h0000_0413 and resp 2'b00 two cycles later.
- LATENCY=3, AR addr 32'h8000_0010:
  - mem_addr_o=4.
  - slv_r_valid_o rises 5 cycles after the AR handshake edge.
- Backpressure: hold slv_r_ready_i=0 for 6 cycles during RESP:
  - valid, data and resp remain constant.
  - slv_ar_ready_o stays 0.
  - One cycle after ready rises, slv_ar_ready_o=1.
- AR addr 32'h7FFF_FFFC returns DECERR (2'b11) with data 0. AR addr 32'h8000_0002 returns SLVERR (2'b10). mem_en_o stays 0 in both cases.
- AR addr 32'h8004_0000 with DEPTH_WORDS=65536 returns DECERR (first out-of-window word). 32'h8003_FFFC returns OKAY with mem_addr_o=16'hFFFF.
- Assert rst_i=0 during DELAY with LATENCY=4:
  - All outputs drop to reset values within the same cycle.
  - No mem_en_o pulse follows.
  - After release, a fresh read completes normally.
